// File: rtl/axi_led_pwm.sv
// AXI4-Lite LED controller: per-LED PWM duty, shared prescaled counter.
// Optional blink gating is enabled with `define AXI_LED_PWM_BLINK_EN.
module axi_led_pwm #(
  parameter int AXI_ADDR_BW_p  = 12,
  parameter int LED_NBR_p      = 8,
  parameter int PWM_BW_p       = 8,
  parameter int PRESCALE_RST_p = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  output logic                     o_axi_awready,
  input  logic [31:0]              i_axi_wdata,
  input  logic [3:0]               i_axi_wstrb,
  input  logic                     i_axi_wvalid,
  output logic                     o_axi_wready,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_bvalid,
  input  logic                     i_axi_bready,
  input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
  input  logic                     i_axi_arvalid,
  output logic                     o_axi_arready,
  output logic [31:0]              o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_axi_rvalid,
  input  logic                     i_axi_rready,
  output logic [LED_NBR_p-1:0]     o_led
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [PWM_BW_p-1:0] CNT_LAST =
    PWM_BW_p'((1 << PWM_BW_p) - 2);

  logic                 en_q, en_d;
  logic [LED_NBR_p-1:0] led_on_q, led_on_d;
  logic [15:0]          presc_reg_q, presc_reg_d;
  logic [PWM_BW_p-1:0]  duty_q [LED_NBR_p];
  logic [PWM_BW_p-1:0]  duty_d [LED_NBR_p];

  logic                 bvalid_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [31:0]          rdata_q;
  logic [1:0]           rresp_d;
  logic [31:0]          rdata_d;

  logic [15:0]          pre_q;
  logic [PWM_BW_p-1:0]  cnt_q;
  logic [LED_NBR_p-1:0] led_q, led_d;
  logic                 tick;

  logic [31:0]          wword, rword, bmask;
  logic                 w_acc, r_acc, w_ok;
  logic                 ws_ctrl, ws_on, ws_pre;
  logic [LED_NBR_p-1:0] ws_duty;
  logic [LED_NBR_p-1:0] blink_gate;

`ifdef AXI_LED_PWM_BLINK_EN
  logic [15:0]          half_q, half_d;
  logic [LED_NBR_p-1:0] mask_q, mask_d;
  logic [15:0]          bcnt_q;
  logic                 phase_q;
  logic                 ws_half, ws_mask, wrap;
`endif

  assign w_acc = i_axi_awvalid & i_axi_wvalid & ~bvalid_q;
  assign r_acc = i_axi_arvalid & ~rvalid_q;

  assign o_axi_awready = w_acc;
  assign o_axi_wready  = w_acc;
  assign o_axi_bvalid  = bvalid_q;
  assign o_axi_bresp   = bresp_q;
  assign o_axi_arready = ~rvalid_q;
  assign o_axi_rvalid  = rvalid_q;
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rresp   = rresp_q;
  assign o_led         = led_q;

  assign wword = 32'(i_axi_awaddr[AXI_ADDR_BW_p-1:2]);
  assign rword = 32'(i_axi_araddr[AXI_ADDR_BW_p-1:2]);
  assign bmask = {{8{i_axi_wstrb[3]}}, {8{i_axi_wstrb[2]}},
                  {8{i_axi_wstrb[1]}}, {8{i_axi_wstrb[0]}}};

  logic unused_bits;
  assign unused_bits = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0],
                         i_axi_wdata, bmask};

  // Write address decode and byte-masked next register values
  always_comb begin
    ws_ctrl = (wword == 32'd0);
    ws_on   = (wword == 32'd1);
    ws_pre  = (wword == 32'd2);
    for (int i = 0; i < LED_NBR_p; i++)
      ws_duty[i] = (wword == 32'(8 + i));
    w_ok = ws_ctrl | ws_on | ws_pre | (|ws_duty);
`ifdef AXI_LED_PWM_BLINK_EN
    ws_half = (wword == 32'd3);
    ws_mask = (wword == 32'd4);
    w_ok    = w_ok | ws_half | ws_mask;
`endif
    en_d        = en_q;
    led_on_d    = led_on_q;
    presc_reg_d = presc_reg_q;
    for (int i = 0; i < LED_NBR_p; i++)
      duty_d[i] = duty_q[i];
    if (w_acc && ws_ctrl)
      en_d = bmask[0] ? i_axi_wdata[0] : en_q;
    if (w_acc && ws_on)
      led_on_d = (led_on_q & ~bmask[LED_NBR_p-1:0]) |
                 (i_axi_wdata[LED_NBR_p-1:0] & bmask[LED_NBR_p-1:0]);
    if (w_acc && ws_pre)
      presc_reg_d = (presc_reg_q & ~bmask[15:0]) |
                    (i_axi_wdata[15:0] & bmask[15:0]);
    for (int i = 0; i < LED_NBR_p; i++)
      if (w_acc && ws_duty[i])
        duty_d[i] = (duty_q[i] & ~bmask[PWM_BW_p-1:0]) |
                    (i_axi_wdata[PWM_BW_p-1:0] & bmask[PWM_BW_p-1:0]);
`ifdef AXI_LED_PWM_BLINK_EN
    half_d = half_q;
    mask_d = mask_q;
    if (w_acc && ws_half)
      half_d = (half_q & ~bmask[15:0]) |
               (i_axi_wdata[15:0] & bmask[15:0]);
    if (w_acc && ws_mask)
      mask_d = (mask_q & ~bmask[LED_NBR_p-1:0]) |
               (i_axi_wdata[LED_NBR_p-1:0] & bmask[LED_NBR_p-1:0]);
`endif
  end

  // Read mux; anything unmapped answers DEADDEAD with SLVERR
  always_comb begin
    rdata_d = 32'hDEADDEAD;
    rresp_d = SLVERR;
    unique case (1'b1)
      (rword == 32'd0): begin
        rdata_d = {31'b0, en_q};
        rresp_d = OKAY;
      end
      (rword == 32'd1): begin
        rdata_d = 32'(led_on_q);
        rresp_d = OKAY;
      end
      (rword == 32'd2): begin
        rdata_d = {16'b0, presc_reg_q};
        rresp_d = OKAY;
      end
`ifdef AXI_LED_PWM_BLINK_EN
      (rword == 32'd3): begin
        rdata_d = {16'b0, half_q};
        rresp_d = OKAY;
      end
      (rword == 32'd4): begin
        rdata_d = 32'(mask_q);
        rresp_d = OKAY;
      end
`endif
      default: begin
        for (int i = 0; i < LED_NBR_p; i++)
          if (rword == 32'(8 + i)) begin
            rdata_d = 32'(duty_q[i]);
            rresp_d = OKAY;
          end
      end
    endcase
  end

  // Register file and AXI response state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      led_on_q    <= '0;
      presc_reg_q <= 16'(PRESCALE_RST_p);
      for (int i = 0; i < LED_NBR_p; i++)
        duty_q[i] <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= OKAY;
      rvalid_q    <= 1'b0;
      rresp_q     <= OKAY;
      rdata_q     <= '0;
    end else begin
      en_q        <= en_d;
      led_on_q    <= led_on_d;
      presc_reg_q <= presc_reg_d;
      for (int i = 0; i < LED_NBR_p; i++)
        duty_q[i] <= duty_d[i];
      if (w_acc) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_ok ? OKAY : SLVERR;
      end else if (i_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (r_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (i_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign tick = (pre_q == presc_reg_q);

  // Prescaler and PWM period counter; a PRESCALE write restarts the prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      if ((w_acc && ws_pre) || tick)
        pre_q <= '0;
      else
        pre_q <= pre_q + 16'd1;
      if (tick)
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

`ifdef AXI_LED_PWM_BLINK_EN
  assign wrap = tick && (cnt_q == CNT_LAST);

  // Blink registers and phase: toggles after BLINK_HALF PWM periods
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q  <= '0;
      mask_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      half_q <= half_d;
      mask_q <= mask_d;
      if (w_acc && ws_half) begin
        bcnt_q  <= '0;
        phase_q <= 1'b0;
      end else if (wrap && half_q != 16'd0) begin
        if (bcnt_q == half_q - 16'd1) begin
          bcnt_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          bcnt_q <= bcnt_q + 16'd1;
        end
      end
    end
  end

  assign blink_gate = ~mask_q |
                      {LED_NBR_p{phase_q | (half_q == 16'd0)}};
`else
  assign blink_gate = '1;
`endif

  // LED drive condition, one register stage to the pins
  always_comb begin
    for (int i = 0; i < LED_NBR_p; i++)
      led_d[i] = en_q & led_on_q[i] & (cnt_q < duty_q[i]) & blink_gate[i];
  end

  // Registered LED outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      led_q <= '0;
    else
      led_q <= led_d;
  end

endmodule

// File: tb/tb_axi_led_pwm.sv
// Directed bench for axi_led_pwm (default build, blink feature off).
// PRESCALE reset value overridden to 5 so the reset read is meaningful.
module tb_axi_led_pwm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [11:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [7:0]  led;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_led_pwm #(
    .AXI_ADDR_BW_p(12),
    .LED_NBR_p(8),
    .PWM_BW_p(8),
    .PRESCALE_RST_p(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid),
    .o_axi_awready(awready),
    .i_axi_wdata(wdata), .i_axi_wstrb(wstrb),
    .i_axi_wvalid(wvalid), .o_axi_wready(wready),
    .o_axi_bresp(bresp), .o_axi_bvalid(bvalid),
    .i_axi_bready(bready),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid),
    .o_axi_arready(arready),
    .o_axi_rdata(rdata), .o_axi_rresp(rresp),
    .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .o_led(led)
  );

  // Write; bvalid must be visible right after the accept edge.
  task automatic axi_wr(input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [1:0] resp,
                        output bit late);
    late = 1'b1;
    resp = 2'bxx;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (awready && wready) begin
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (bvalid) begin
          resp = bresp;
          late = 1'b0;
        end
        @(posedge clk); #1;
        break;
      end
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_rd(input logic [11:0] a, output logic [31:0] d,
                        output logic [1:0] resp, output bit late);
    late = 1'b1;
    d = 'x;
    resp = 2'bxx;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (arready) begin
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (rvalid) begin
          d = rdata;
          resp = rresp;
          late = 1'b0;
        end
        @(posedge clk); #1;
        break;
      end
      @(negedge clk);
    end
    arvalid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    bit          late;
    #17;
    total++;
    if (led !== 8'h00 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs: led=%h bvalid=%b rvalid=%b need 00/0/0",
               led, bvalid, rvalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    axi_rd(12'h008, d, r, late);
    total++;
    if (late || d !== 32'd5 || r !== 2'b00) begin
      bad++;
      $display("FAIL reset_prescale: got %h/%b late=%0d need 5/00",
               d, r, late);
    end
  endtask

  task automatic test_led_on();
    logic [31:0] d;
    logic [1:0]  r;
    bit          late;
    axi_wr(12'h004, 32'h0000_00A5, 4'b0001, r, late);
    total++;
    if (late || r !== 2'b00) begin
      bad++;
      $display("FAIL led_on_bresp: got %b late=%0d need 00", r, late);
    end
    axi_rd(12'h004, d, r, late);
    total++;
    if (late || d !== 32'hA5 || r !== 2'b00) begin
      bad++;
      $display("FAIL led_on_read: got %h/%b need a5/00", d, r);
    end
    axi_wr(12'h004, 32'hFFFF_FFFF, 4'b0010, r, late);
    axi_rd(12'h004, d, r, late);
    total++;
    if (late || d !== 32'hA5) begin
      bad++;
      $display("FAIL led_on_upper: got %h need a5", d);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    bit          late;
    axi_wr(12'h000, 32'hFFFF_FFFF, 4'b0000, r, late);
    axi_rd(12'h000, d, r, late);
    total++;
    if (late || d !== 32'h0) begin
      bad++;
      $display("FAIL strb_zero: got %h need 0", d);
    end
    axi_wr(12'h000, 32'hFFFF_FFFF, 4'b0001, r, late);
    axi_rd(12'h003, d, r, late);
    total++;
    if (late || d !== 32'h1 || r !== 2'b00) begin
      bad++;
      $display("FAIL strb_one: got %h/%b need 1/00", d, r);
    end
    axi_wr(12'h03C, 32'h1234_56AB, 4'b1111, r, late);
    axi_rd(12'h03C, d, r, late);
    total++;
    if (late || d !== 32'hAB || r !== 2'b00) begin
      bad++;
      $display("FAIL duty7_read: got %h/%b need ab/00", d, r);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [1:0]  r;
    bit          late;
    axi_wr(12'h800, 32'h1, 4'b1111, r, late);
    total++;
    if (late || r !== 2'b10) begin
      bad++;
      $display("FAIL unmapped_bresp: got %b need 10", r);
    end
    axi_rd(12'h800, d, r, late);
    total++;
    if (late || d !== 32'hDEADDEAD || r !== 2'b10) begin
      bad++;
      $display("FAIL unmapped_read: got %h/%b need deaddead/10", d, r);
    end
    axi_rd(12'h040, d, r, late);
    total++;
    if (late || d !== 32'hDEADDEAD || r !== 2'b10) begin
      bad++;
      $display("FAIL duty8_read: got %h/%b need deaddead/10", d, r);
    end
    axi_wr(12'h00C, 32'h1, 4'b1111, r, late);
    total++;
    if (late || r !== 2'b10) begin
      bad++;
      $display("FAIL blink_off_bresp: got %b need 10", r);
    end
  endtask

  // Counts cycles with led[0] high over n clocks; also led[1]
  task automatic count_led(input int n, output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (led[0] === 1'b1) h0++;
      if (led[1] === 1'b1) h1++;
    end
  endtask

  task automatic test_pwm();
    logic [1:0] r;
    bit         late;
    int         h0, h1;
    axi_wr(12'h008, 32'h0, 4'b1111, r, late);
    axi_wr(12'h004, 32'h1, 4'b1111, r, late);
    axi_wr(12'h000, 32'h1, 4'b1111, r, late);
    axi_wr(12'h020, 32'd64, 4'b1111, r, late);
    count_led(255, h0, h1);
    total++;
    if (h0 != 64 || h1 != 0) begin
      bad++;
      $display("FAIL pwm_64: high=%0d led1=%0d need 64/0", h0, h1);
    end
    count_led(510, h0, h1);
    total++;
    if (h0 != 128) begin
      bad++;
      $display("FAIL pwm_64x2: high=%0d need 128", h0);
    end
    axi_wr(12'h008, 32'h1, 4'b0001, r, late);
    count_led(510, h0, h1);
    total++;
    if (h0 != 128) begin
      bad++;
      $display("FAIL pwm_presc1: high=%0d need 128", h0);
    end
    axi_wr(12'h008, 32'h0, 4'b0001, r, late);
    axi_wr(12'h020, 32'd255, 4'b0001, r, late);
    count_led(300, h0, h1);
    total++;
    if (h0 != 300) begin
      bad++;
      $display("FAIL pwm_max: high=%0d need 300", h0);
    end
    axi_wr(12'h020, 32'd0, 4'b0001, r, late);
    count_led(300, h0, h1);
    total++;
    if (h0 != 0) begin
      bad++;
      $display("FAIL pwm_zero: high=%0d need 0", h0);
    end
    axi_wr(12'h020, 32'd255, 4'b0001, r, late);
    axi_wr(12'h000, 32'h0, 4'b0001, r, late);
    count_led(300, h0, h1);
    total++;
    if (h0 != 0) begin
      bad++;
      $display("FAIL pwm_en_off: high=%0d need 0", h0);
    end
    axi_wr(12'h000, 32'h1, 4'b0001, r, late);
  endtask

  task automatic test_backpressure();
    int          acc, bv, stable;
    logic [31:0] d0;
    @(negedge clk);
    awaddr = 12'h004; wdata = 32'h1; wstrb = 4'b0001;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    acc = 0; bv = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (awready) acc++;
      if (bvalid) bv++;
      @(negedge clk);
    end
    total++;
    if (acc != 1 || bv != 5) begin
      bad++;
      $display("FAIL bp_write: accepts=%0d bvalid_cycles=%0d need 1/5",
               acc, bv);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bvalid !== 1'b0) begin
      bad++;
      $display("FAIL bp_bclear: bvalid=%b need 0", bvalid);
    end
    @(negedge clk);
    araddr = 12'h004; arvalid = 1'b1; rready = 1'b0;
    acc = 0; stable = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (arready) acc++;
      if (rvalid && rdata === 32'h1 && rresp === 2'b00) stable++;
      @(negedge clk);
    end
    total++;
    if (acc != 1 || stable != 5) begin
      bad++;
      $display("FAIL bp_read: accepts=%0d stable=%0d need 1/5",
               acc, stable);
    end
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rvalid !== 1'b0) begin
      bad++;
      $display("FAIL bp_rclear: rvalid=%b need 0", rvalid);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic [1:0]  r;
    bit          late;
    int          h0, h1;
    count_led(10, h0, h1);
    total++;
    if (h0 != 10) begin
      bad++;
      $display("FAIL pre_rst_led: high=%0d need 10", h0);
    end
    @(negedge clk);
    awaddr = 12'h000; wdata = 32'h0; wstrb = 4'b0001;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 12'h000; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (led !== 8'h00 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: led=%h bvalid=%b rvalid=%b need 00/0/0",
               led, bvalid, rvalid);
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    axi_rd(12'h008, d, r, late);
    total++;
    if (late || d !== 32'd5 || r !== 2'b00) begin
      bad++;
      $display("FAIL post_rst_presc: got %h/%b need 5/00", d, r);
    end
    axi_rd(12'h020, d, r, late);
    total++;
    if (late || d !== 32'd0 || r !== 2'b00) begin
      bad++;
      $display("FAIL post_rst_duty: got %h/%b need 0/00", d, r);
    end
  endtask

  initial begin
    test_reset();
    test_led_on();
    test_strobe();
    test_unmapped();
    test_backpressure();
    test_pwm();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
